// File: rtl/rename_regfile.sv
// Architectural register file with a per-register rename table (busy bit + ROB tag).
// Dispatch reads see committed data, a pending tag, or same-cycle commit data.
module rename_regfile #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              rename_valid,
    input  logic [REG_W-1:0]  rename_reg,
    input  logic [TAG_W-1:0]  rename_tag,
    input  logic [REG_W-1:0]  rs1_addr,
    output logic              rs1_busy,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [REG_W-1:0]  rs2_addr,
    output logic              rs2_busy,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              commit_valid,
    input  logic [REG_W-1:0]  commit_reg,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [DATA_W-1:0] commit_data
);

    logic [DATA_W-1:0] data_q [REG_NUM];
    logic [TAG_W-1:0]  tag_q  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic commit_hit;
    assign commit_hit = busy_q[commit_reg] && (tag_q[commit_reg] == commit_tag);

    // Later assignments win: clear beats commit release, rename beats commit release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (commit_valid && (commit_reg != '0)) begin
                data_q[commit_reg] <= commit_data;
                if (commit_hit) begin
                    busy_q[commit_reg] <= 1'b0;
                end
            end
            if (clear) begin
                busy_q <= '0;
            end else if (rename_valid && (rename_reg != '0)) begin
                busy_q[rename_reg] <= 1'b1;
                tag_q[rename_reg]  <= rename_tag;
            end
        end
    end

    // A commit retiring the current mapping is forwarded straight to dispatch.
    always_comb begin
        rs1_busy = 1'b0;
        rs1_tag  = '0;
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_busy = busy_q[rs1_addr];
            rs1_tag  = tag_q[rs1_addr];
            rs1_data = data_q[rs1_addr];
            if (commit_valid && (commit_reg == rs1_addr) && commit_hit) begin
                rs1_busy = 1'b0;
                rs1_data = commit_data;
            end
        end
    end

    always_comb begin
        rs2_busy = 1'b0;
        rs2_tag  = '0;
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_busy = busy_q[rs2_addr];
            rs2_tag  = tag_q[rs2_addr];
            rs2_data = data_q[rs2_addr];
            if (commit_valid && (commit_reg == rs2_addr) && commit_hit) begin
                rs2_busy = 1'b0;
                rs2_data = commit_data;
            end
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: expectations are queued per cycle and
// checked against both read ports shortly after the falling edge.
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        rename_valid = 1'b0;
    logic [4:0]  rename_reg = '0;
    logic [3:0]  rename_tag = '0;
    logic [4:0]  rs1_addr = '0;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr = '0;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;
    logic [31:0] rs2_data;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_reg = '0;
    logic [3:0]  commit_tag = '0;
    logic [31:0] commit_data = '0;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [4:0]  addr;
        logic        busy;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    rename_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .clear        (clear),
        .rename_valid (rename_valid),
        .rename_reg   (rename_reg),
        .rename_tag   (rename_tag),
        .rs1_addr     (rs1_addr),
        .rs1_busy     (rs1_busy),
        .rs1_tag      (rs1_tag),
        .rs1_data     (rs1_data),
        .rs2_addr     (rs2_addr),
        .rs2_busy     (rs2_busy),
        .rs2_tag      (rs2_tag),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_reg   (commit_reg),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data)
    );

    // Long low phase leaves room for up to ~40 one-unit reads per cycle.
    always #50 clk = ~clk;

    task automatic push_exp(input logic [4:0] a, input logic b, input logic [3:0] t,
                            input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.busy = b;
        e.tag  = t;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        rdy          = 1'b1;
        clear        = 1'b0;
        rename_valid = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [3:0] t);
        rename_valid = 1'b1;
        rename_reg   = r;
        rename_tag   = t;
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
        commit_valid = 1'b1;
        commit_reg   = r;
        commit_tag   = t;
        commit_data  = d;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            case (c)
                0: begin
                    push_exp(5, 1'b0, 4'd0, 32'h0);
                    push_exp(0, 1'b0, 4'd0, 32'h0);
                end
                1: begin
                    rst = 1'b1;
                    do_rename(5, 4'd3);
                    do_commit(6, 4'd0, 32'h77);
                end
                2: begin
                    push_exp(5, 1'b1, 4'd3, 32'h0);
                    push_exp(6, 1'b0, 4'd0, 32'h77);
                end
                default: begin
                    rst = 1'b0;
                    push_exp(5, 1'b0, 4'd0, 32'h0);
                    push_exp(6, 1'b0, 4'd0, 32'h0);
                end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rs1_addr = e.addr;
                rs2_addr = e.addr;
                #1;
                checks++;
                if ({rs1_busy, rs1_tag, rs1_data} !== {e.busy, e.tag, e.data} ||
                    {rs2_busy, rs2_tag, rs2_data} !== {e.busy, e.tag, e.data}) begin
                    fails++;
                    $display("[TB] FAIL reset x%0d: got busy=%b/%b tag=%0d/%0d data=%h/%h, expected busy=%b tag=%0d data=%h",
                             e.addr, rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_data, rs2_data,
                             e.busy, e.tag, e.data);
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_commit_bypass();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            case (c)
                0: begin
                    do_rename(5, 4'd3);
                    push_exp(5, 1'b0, 4'd0, 32'h0);
                end
                1: push_exp(5, 1'b1, 4'd3, 32'h0);
                2: begin
                    do_commit(5, 4'd3, 32'hDEAD);
                    push_exp(5, 1'b0, 4'd3, 32'hDEAD);
                end
                default: push_exp(5, 1'b0, 4'd3, 32'hDEAD);
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rs1_addr = e.addr;
                rs2_addr = e.addr;
                #1;
                checks++;
                if ({rs1_busy, rs1_tag, rs1_data} !== {e.busy, e.tag, e.data} ||
                    {rs2_busy, rs2_tag, rs2_data} !== {e.busy, e.tag, e.data}) begin
                    fails++;
                    $display("[TB] FAIL commit_bypass c%0d x%0d: got busy=%b/%b tag=%0d/%0d data=%h/%h, expected busy=%b tag=%0d data=%h",
                             c, e.addr, rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_data, rs2_data,
                             e.busy, e.tag, e.data);
                end
            end
        end
    endtask

    task automatic test_younger_rename();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            case (c)
                0: do_rename(7, 4'd2);
                1: begin
                    do_rename(7, 4'd6);
                    push_exp(7, 1'b1, 4'd2, 32'h0);
                end
                2: begin
                    do_commit(7, 4'd2, 32'h11);
                    push_exp(7, 1'b1, 4'd6, 32'h0);
                end
                default: push_exp(7, 1'b1, 4'd6, 32'h11);
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rs1_addr = e.addr;
                rs2_addr = e.addr;
                #1;
                checks++;
                if ({rs1_busy, rs1_tag, rs1_data} !== {e.busy, e.tag, e.data} ||
                    {rs2_busy, rs2_tag, rs2_data} !== {e.busy, e.tag, e.data}) begin
                    fails++;
                    $display("[TB] FAIL younger_rename c%0d x%0d: got busy=%b/%b tag=%0d/%0d data=%h/%h, expected busy=%b tag=%0d data=%h",
                             c, e.addr, rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_data, rs2_data,
                             e.busy, e.tag, e.data);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            case (c)
                0: begin
                    do_rename(9, 4'd4);
                    do_commit(9, 4'd1, 32'h55);
                    push_exp(9, 1'b0, 4'd0, 32'h0);
                end
                1: begin
                    do_rename(10, 4'd5);
                    push_exp(9, 1'b1, 4'd4, 32'h55);
                end
                2: begin
                    do_rename(10, 4'd7);
                    do_commit(10, 4'd5, 32'h66);
                    push_exp(10, 1'b0, 4'd5, 32'h66);
                end
                default: push_exp(10, 1'b1, 4'd7, 32'h66);
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rs1_addr = e.addr;
                rs2_addr = e.addr;
                #1;
                checks++;
                if ({rs1_busy, rs1_tag, rs1_data} !== {e.busy, e.tag, e.data} ||
                    {rs2_busy, rs2_tag, rs2_data} !== {e.busy, e.tag, e.data}) begin
                    fails++;
                    $display("[TB] FAIL same_cycle c%0d x%0d: got busy=%b/%b tag=%0d/%0d data=%h/%h, expected busy=%b tag=%0d data=%h",
                             c, e.addr, rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_data, rs2_data,
                             e.busy, e.tag, e.data);
                end
            end
        end
    endtask

    task automatic test_clear();
        exp_t e;
        logic [31:0] d;
        logic [4:0]  r;
        for (int c = 0; c < 33; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c < 31) begin
                r = 5'(c + 1);
                do_rename(r, r[3:0]);
            end else if (c == 31) begin
                clear = 1'b1;
                do_rename(3, 4'd8);
                do_commit(12, 4'd0, 32'hC0DE);
                push_exp(1, 1'b1, 4'd1, 32'h0);
                push_exp(3, 1'b1, 4'd3, 32'h0);
                push_exp(12, 1'b1, 4'd12, 32'h0);
            end else begin
                push_exp(0, 1'b0, 4'd0, 32'h0);
                for (int i = 1; i < 32; i++) begin
                    case (i)
                        5:       d = 32'hDEAD;
                        7:       d = 32'h11;
                        9:       d = 32'h55;
                        10:      d = 32'h66;
                        12:      d = 32'hC0DE;
                        default: d = 32'h0;
                    endcase
                    r = 5'(i);
                    push_exp(r, 1'b0, r[3:0], d);
                end
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rs1_addr = e.addr;
                rs2_addr = e.addr;
                #1;
                checks++;
                if ({rs1_busy, rs1_tag, rs1_data} !== {e.busy, e.tag, e.data} ||
                    {rs2_busy, rs2_tag, rs2_data} !== {e.busy, e.tag, e.data}) begin
                    fails++;
                    $display("[TB] FAIL clear c%0d x%0d: got busy=%b/%b tag=%0d/%0d data=%h/%h, expected busy=%b tag=%0d data=%h",
                             c, e.addr, rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_data, rs2_data,
                             e.busy, e.tag, e.data);
                end
            end
        end
    endtask

    task automatic test_x0_and_rdy();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            case (c)
                0: begin
                    do_rename(0, 4'd5);
                    do_commit(0, 4'd0, 32'hFFFF);
                    push_exp(0, 1'b0, 4'd0, 32'h0);
                end
                1: push_exp(0, 1'b0, 4'd0, 32'h0);
                2: begin
                    rdy = 1'b0;
                    do_commit(5, 4'd5, 32'hBEEF);
                    do_rename(11, 4'd9);
                    push_exp(5, 1'b0, 4'd5, 32'hDEAD);
                end
                default: begin
                    push_exp(5, 1'b0, 4'd5, 32'hDEAD);
                    push_exp(11, 1'b0, 4'd11, 32'h0);
                end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rs1_addr = e.addr;
                rs2_addr = e.addr;
                #1;
                checks++;
                if ({rs1_busy, rs1_tag, rs1_data} !== {e.busy, e.tag, e.data} ||
                    {rs2_busy, rs2_tag, rs2_data} !== {e.busy, e.tag, e.data}) begin
                    fails++;
                    $display("[TB] FAIL x0_rdy c%0d x%0d: got busy=%b/%b tag=%0d/%0d data=%h/%h, expected busy=%b tag=%0d data=%h",
                             c, e.addr, rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_data, rs2_data,
                             e.busy, e.tag, e.data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit_bypass();
        test_younger_rename();
        test_same_cycle();
        test_clear();
        test_x0_and_rdy();
        @(negedge clk);
        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
